// File: rtl/fetch_unit.sv
// Instruction fetch: issues word-aligned requests and buffers in-order responses with their PCs.
// Latency: a response is visible on instr_* the cycle after it arrives (two cycles after request with 1-cycle memory).
// Backpressure: requests are credit-limited to DEPTH (in-flight plus buffered); a redirect flushes and drops in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic {ST_FETCH = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_out_nxt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_buf_dat [DEPTH];
  logic [31:0]   r_buf_pc  [DEPTH];
  logic          w_head_vld;
  logic          w_pop;
  logic          w_push;
  logic          w_acc;
  logic          w_rsp;
  logic [CW:0]   w_used;
  logic [31:0]   w_rsp_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Responses return in order, so the oldest in-flight request sits outstanding words behind fetch_pc.
  assign w_rsp_pc = r_fetch_pc - 32'({r_outstanding, 2'b00});

  // Next-state logic plus request/handshake decode; a slot popped this cycle already counts as free credit.
  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    w_push         = 1'b0;
    w_rsp          = imem_rsp_valid && (r_outstanding != '0);
    w_head_vld     = !rst && (r_count != '0) && !redirect_valid;
    w_pop          = w_head_vld && instr_ready;
    w_used         = {1'b0, r_outstanding} + {1'b0, r_count} - {{CW{1'b0}}, w_pop};
    case (r_state)
      ST_FETCH: begin
        imem_req_valid = !rst && !redirect_valid && (w_used < DEPTH_C);
        w_push         = w_rsp && !redirect_valid;
      end
      ST_FLUSH: begin
        if (w_rsp && (r_drop_cnt == CW'(1))) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
    w_acc     = imem_req_valid && imem_req_ready;
    w_out_nxt = r_outstanding + CW'(w_acc) - CW'(w_rsp);
    if (redirect_valid) w_state_nxt = (w_out_nxt != '0) ? ST_FLUSH : ST_FETCH;
  end

  // Output mux; everything reads as idle/zero while reset is held.
  always_comb begin
    imem_req_addr = rst ? RESET_PC : r_fetch_pc;
    instr_valid   = w_head_vld;
    instr_out     = '0;
    instr_pc      = '0;
    if (!rst && (r_count != '0)) begin
      instr_out = r_buf_dat[r_rd_ptr];
      instr_pc  = r_buf_pc[r_rd_ptr];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Fetch PC, in-flight/drop accounting and buffer pointers; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_drop_cnt <= w_out_nxt;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_acc) r_fetch_pc <= r_fetch_pc + 32'd4;
        if ((r_state == ST_FLUSH) && w_rsp) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Buffer storage: instruction word and its PC travel together.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_buf_dat[r_wr_ptr] <= imem_rsp_data;
      r_buf_pc[r_wr_ptr]  <= w_rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: queue-based reference model plus directed scenarios with literal pins.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        instr_valid, instr_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, instr_out, instr_pc;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc), .instr_ready(instr_ready));

  // Second instance with a reset PC near the top of the address space, 1-cycle memory.
  logic        wr_req_vld, wr_rsp_vld, wr_ivld;
  logic [31:0] wr_req_addr, wr_rsp_dat, wr_iout, wr_ipc;
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(wr_req_vld), .imem_req_addr(wr_req_addr), .imem_req_ready(1'b1),
    .imem_rsp_valid(wr_rsp_vld), .imem_rsp_data(wr_rsp_dat),
    .instr_valid(wr_ivld), .instr_out(wr_iout), .instr_pc(wr_ipc), .instr_ready(1'b1));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // memory model
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int fixed_lat = 0;

  // reference model: in-flight requests (with drop mark) and the instruction buffer
  typedef struct { logic [31:0] pc; bit drop; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] dat; } ent_t;
  fl_t  m_fl[$];
  ent_t m_buf[$];
  logic [31:0] m_pc = RPC;

  // observations for directed pins
  logic [31:0] acc_log[$];
  logic [31:0] hs_log[$];
  logic [31:0] w_log[$];
  int tcyc, first_vld;
  logic o_req, o_ivld;
  logic [31:0] o_addr, o_ipc, o_iout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] at_acc(input int i);
    return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] at_hs(input int i);
    return (hs_log.size() > i) ? hs_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    acc_log.delete();
    hs_log.delete();
    tcyc = 0;
    first_vld = -1;
  endtask

  task automatic run_cycle(input bit r, input bit redir, input logic [31:0] rpc,
                           input bit irdy, input bit qrdy);
    bit e_ivld, e_pop, e_req, m_flush, d_acc, e_acc;
    logic [31:0] e_addr, d_addr;
    fl_t f;
    ent_t e;
    rst = r; redirect_valid = redir; redirect_pc = rpc;
    instr_ready = irdy; imem_req_ready = qrdy;
    if (!r && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    m_flush = 1'b0;
    foreach (m_fl[i]) if (m_fl[i].drop) m_flush = 1'b1;
    e_ivld = !r && (m_buf.size() > 0) && !redir;
    e_pop  = e_ivld && irdy;
    e_req  = !r && !m_flush && !redir && ((m_fl.size() + m_buf.size() - (e_pop ? 1 : 0)) < DEPTH);
    e_addr = r ? RPC : m_pc;
    e_acc  = e_req && qrdy;
    chk("req_valid", 32'(imem_req_valid), 32'(e_req));
    chk("req_addr", imem_req_addr, e_addr);
    chk("instr_valid", 32'(instr_valid), 32'(e_ivld));
    if (e_ivld) begin
      chk("instr_out", instr_out, m_buf[0].dat);
      chk("instr_pc", instr_pc, m_buf[0].pc);
    end else if (r) begin
      chk("instr_out_rst", instr_out, 32'h0);
      chk("instr_pc_rst", instr_pc, 32'h0);
    end
    d_acc = imem_req_valid && imem_req_ready;
    d_addr = imem_req_addr;
    o_req = imem_req_valid; o_addr = imem_req_addr; o_ivld = instr_valid;
    o_ipc = instr_pc; o_iout = instr_out;
    if (d_acc) acc_log.push_back(d_addr);
    if (instr_valid && instr_ready) hs_log.push_back(instr_pc);
    if (instr_valid && first_vld < 0) first_vld = tcyc;
    @(posedge clk);
    if (r) begin
      m_pc = RPC; m_fl.delete(); m_buf.delete(); mem_q.delete();
    end else begin
      if (e_pop) e = m_buf.pop_front();
      if (imem_rsp_valid && m_fl.size() > 0) begin
        f = m_fl.pop_front();
        if (!f.drop && !redir) m_buf.push_back('{f.pc, imem_rsp_data});
      end
      if (e_acc) begin
        m_fl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (redir) begin
        m_pc = {rpc[31:2], 2'b00};
        m_buf.delete();
        foreach (m_fl[i]) m_fl[i].drop = 1'b1;
      end
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (d_acc) mem_q.push_back('{d_addr, cyc + 1 + ((fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3)))});
    end
    cyc++;
    tcyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    repeat (n) run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    clear_logs();
  endtask

  // 1-cycle memory for the wrap instance; logs its first three accepted addresses.
  initial begin
    logic wacc;
    logic [31:0] waddr;
    wr_rsp_vld = 1'b0;
    wr_rsp_dat = 32'h0;
    forever begin
      @(negedge clk);
      wacc  = wr_req_vld;
      waddr = wr_req_addr;
      if (wacc && w_log.size() < 3) w_log.push_back(waddr);
      @(posedge clk);
      #1;
      wr_rsp_vld = wacc && !rst;
      wr_rsp_dat = mem_word(waddr);
    end
  end

  initial begin
    int prdy[4] = '{90, 30, 80, 60};
    int pqr[4]  = '{90, 80, 30, 60};
    int pred[4] = '{3, 5, 5, 15};
    logic [31:0] rpc;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; instr_ready = 1'b1;

    // reset state, then back-to-back fetch with 1-cycle memory
    fixed_lat = 0;
    do_reset(3);
    chk("rst_req_vld", 32'(o_req), 32'h0);
    chk("rst_addr", o_addr, 32'h0);
    repeat (8) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("a_acc0", at_acc(0), 32'h0);
    chk("a_acc1", at_acc(1), 32'h4);
    chk("a_acc2", at_acc(2), 32'h8);
    chk("a_first_vld_cycle", 32'(first_vld), 32'd2);
    chk("a_first_pc", at_hs(0), 32'h0);
    chk("a_handshakes", 32'(hs_log.size()), 32'd6);

    // consumer stalled: credits cap requests at DEPTH, head holds
    do_reset(2);
    repeat (6) run_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("b_acc_count", 32'(acc_log.size()), 32'd2);
    chk("b_req_low", 32'(o_req), 32'h0);
    chk("b_head_vld", 32'(o_ivld), 32'h1);
    chk("b_head_pc", o_ipc, 32'h0);
    chk("b_head_dat", o_iout, mem_word(32'h0));
    repeat (6) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("b_resume0", at_hs(0), 32'h0);
    chk("b_resume1", at_hs(1), 32'h4);
    chk("b_resume2", at_hs(2), 32'h8);

    // redirect with two outstanding requests: both responses dropped
    fixed_lat = 3;
    do_reset(2);
    repeat (2) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("c_two_out", 32'(acc_log.size()), 32'd2);
    clear_logs();
    run_cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
    repeat (14) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("c_next_req", at_acc(0), 32'h100);
    chk("c_first_pc", at_hs(0), 32'h100);

    // redirect coinciding with the only response: no flush, target fetched next
    fixed_lat = 0;
    do_reset(2);
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("d_req_next", 32'(o_req), 32'h1);
    chk("d_addr_next", o_addr, 32'h200);
    repeat (4) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("d_first_pc", at_hs(0), 32'h200);

    // memory stall holds the address; then reset during a flush
    do_reset(2);
    repeat (3) begin
      run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("e_addr_hold", o_addr, 32'h0);
      chk("e_req_hold", 32'(o_req), 32'h1);
    end
    fixed_lat = 4;
    repeat (2) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("e_flush_req_low", 32'(o_req), 32'h0);
    chk("e_flush_addr", o_addr, 32'h400);
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("e_rst_req", 32'(o_req), 32'h0);
    chk("e_rst_vld", 32'(o_ivld), 32'h0);
    chk("e_rst_addr", o_addr, 32'h0);
    do_reset(1);
    fixed_lat = 0;
    repeat (4) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("e_restart", at_acc(0), 32'h0);

    // randomized traffic across several pressure profiles
    fixed_lat = -1;
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 800; k++) begin
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
        run_cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 99) < pred[ph], rpc,
                  $urandom_range(0, 99) < prdy[ph],
                  $urandom_range(0, 99) < pqr[ph]);
      end
    end

    // wrap instance: addresses roll over from the top of memory
    chk("w_acc0", (w_log.size() > 0) ? w_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    chk("w_acc1", (w_log.size() > 1) ? w_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("w_acc2", (w_log.size() > 2) ? w_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
